// File: rtl/not_8_bits_pkg.sv
// ---------------------------------------------------------------------------
// not_8_bits_pkg
//   Shared constants for the 8-bit NOT stage of the ALU datapath.
//   NOT_WIDTH   : number of inverted bits (fixed by the enumerated scalar ports)
//   NOT_RST_VAL : value the registered copy takes while reset is asserted
// ---------------------------------------------------------------------------
package not_8_bits_pkg;

  localparam int NOT_WIDTH = 8;

  localparam logic [NOT_WIDTH-1:0] NOT_RST_VAL = 8'h00;

endpackage : not_8_bits_pkg

// File: rtl/not_8_bits_not_1_bit.sv
// ---------------------------------------------------------------------------
// not_1_bit
//   Single-bit inverter built from one NOT primitive. X or Z on the input
//   yields X on the output, as the primitive defines.
//   Ports:
//     in  : input bit
//     out : inverted bit
// ---------------------------------------------------------------------------
module not_1_bit (
  input  logic in,
  output logic out
);

  not u_not (out, in);

endmodule : not_1_bit

// File: rtl/not_8_bits.sv
// ---------------------------------------------------------------------------
// not_8_bits
//   8-bit bitwise inverter for the ALU NOT stage. Eight independent
//   single-bit NOT gates drive the combinational outputs S1..S8; a registered
//   copy of the inverted byte (s_q) serves pipelined consumers.
//   Ports:
//     clk     : clock, used only by the registered copy
//     rst     : asynchronous active-high reset, clears s_q only
//     A1..A8  : operand bits, A1 = LSB, A8 = MSB
//     S1..S8  : combinational outputs, S(i) = ~A(i); unaffected by rst / en
//     en      : load enable for s_q
//     s_q     : registered inverted byte, s_q[i] holds S(i+1)
// ---------------------------------------------------------------------------
module not_8_bits
  import not_8_bits_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 A1,
  input  logic                 A2,
  input  logic                 A3,
  input  logic                 A4,
  input  logic                 A5,
  input  logic                 A6,
  input  logic                 A7,
  input  logic                 A8,
  output logic                 S1,
  output logic                 S2,
  output logic                 S3,
  output logic                 S4,
  output logic                 S5,
  output logic                 S6,
  output logic                 S7,
  output logic                 S8,
  input  logic                 en,
  output logic [NOT_WIDTH-1:0] s_q
);

  localparam int WIDTH = NOT_WIDTH;

  // The scalar ports are gathered into buses so the gate array and the
  // register can be written once over WIDTH bits.
  logic [WIDTH-1:0] a_bus;
  logic [WIDTH-1:0] s_bus;

  assign a_bus = {A8, A7, A6, A5, A4, A3, A2, A1};

  // One gate per bit; there is intentionally no cross-bit logic.
  for (genvar i = 0; i < WIDTH; i++) begin : g_not
    not_1_bit u_not_1_bit (
      .in  (a_bus[i]),
      .out (s_bus[i])
    );
  end

  assign S1 = s_bus[0];
  assign S2 = s_bus[1];
  assign S3 = s_bus[2];
  assign S4 = s_bus[3];
  assign S5 = s_bus[4];
  assign S6 = s_bus[5];
  assign S7 = s_bus[6];
  assign S8 = s_bus[7];

  // Registered copy: cleared immediately by rst, loads the gate outputs on a
  // clock edge only when en is high, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= NOT_RST_VAL;
    end else if (en) begin
      s_q <= s_bus;
    end
  end

endmodule : not_8_bits

// File: tb/tb_not_8_bits.sv
// ---------------------------------------------------------------------------
// tb_not_8_bits
//   Self-checking bench for not_8_bits: directed cases followed by random
//   operand / enable / reset traffic, checked against a byte-level model.
// ---------------------------------------------------------------------------
module tb_not_8_bits;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic A1, A2, A3, A4, A5, A6, A7, A8;
  logic S1, S2, S3, S4, S5, S6, S7, S8;
  logic en;
  logic [7:0] s_q;
  logic [7:0] s_obs;

  not_8_bits dut (
    .clk (clk), .rst (rst),
    .A1 (A1), .A2 (A2), .A3 (A3), .A4 (A4),
    .A5 (A5), .A6 (A6), .A7 (A7), .A8 (A8),
    .S1 (S1), .S2 (S2), .S3 (S3), .S4 (S4),
    .S5 (S5), .S6 (S6), .S7 (S7), .S8 (S8),
    .en (en), .s_q (s_q)
  );

  assign s_obs = {S8, S7, S6, S5, S4, S3, S2, S1};

  // ---------------- model / scoreboard state ----------------
  logic [7:0] a_cur;     // operand currently driven
  logic [7:0] exp_sq;    // expected registered byte
  int n_checks = 0;
  int n_fail   = 0;

  // The inverse of a byte is its complement to 255.
  function automatic logic [7:0] model_not(input logic [7:0] v);
    return 8'd255 - v;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive the operand and check the combinational path 1 time unit later.
  task automatic drive_a(input logic [7:0] v, input string tag);
    {A8, A7, A6, A5, A4, A3, A2, A1} = v;
    a_cur = v;
    #1;
    check(tag, s_obs, model_not(v));
  endtask

  // One clock edge, update the model from the sampled controls, check s_q,
  // and return at the falling edge ready for new inputs.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst && en) exp_sq = model_not(a_cur);
    #1;
    check(tag, s_q, exp_sq);
    @(negedge clk);
  endtask

  // Assert reset away from any clock edge and check the async clear.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    exp_sq = 8'h00;
    #1;
    check(tag, s_q, exp_sq);
    check({tag, "_s"}, s_obs, model_not(a_cur));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    en = 1'b0;
    exp_sq = 8'h00;
    {A8, A7, A6, A5, A4, A3, A2, A1} = 8'h00;
    a_cur = 8'h00;
    #1;
    check("reset_sq", s_q, 8'h00);
    check("reset_s", s_obs, 8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Directed combinational patterns (no clock edge needed)
    drive_a(8'hFF, "s_ff");
    drive_a(8'h00, "s_00");
    drive_a(8'h99, "s_99");
    drive_a(8'hF0, "s_f0");
    check("s_f0_hold_sq", s_q, 8'h00);
    en = 1'b1;
    tick("sq_load_0f");

    // Reset while S keeps following A
    drive_a(8'h00, "s_00_pre_rst");
    #2;
    async_reset("sq_async_rst");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    tick("sq_hold_after_rst");
    en = 1'b1;
    tick("sq_load_ff");

    // Walking one, reset asserted half-way through
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h01 << i;
      drive_a(w, "walk_s");
      tick("walk_sq");
      if (i == 4) begin
        #2;
        async_reset("walk_async_rst");
        drive_a(w ^ 8'h0F, "walk_s_in_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      en = 1'($urandom_range(0, 1));
      drive_a(8'($urandom), "rand_s");
      if ($urandom_range(0, 15) == 0) begin
        async_reset("rand_async_rst");
      end else begin
        rst = 1'b0;
      end
      tick("rand_sq");
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_not_8_bits

// File: doc/not_8_bits.md
Name: not_8_bits

Overview:
- 8-bit bitwise inverter built structurally from eight single-bit NOT gates, one per bit; used as the NOT stage of the ALU datapath.
- Primary outputs S1..S8 are purely combinational: S(i) = NOT A(i), with no clock involvement.
- A registered copy of the inverted byte (s_q) is also provided for pipelined consumers, clocked by clk and cleared by rst.

Parameters:
- WIDTH, 8, number of inverted bits. Fixed at 8 because the scalar ports are enumerated; kept only for internal loops and the registered bus.

Ports:
- clk  input  1  system clock; used only by the registered output path.
- rst  input  1  asynchronous, active-high reset; clears the registered path only.
- A1  input  1  operand bit 0 (LSB).
- A2  input  1  operand bit 1.
- A3  input  1  operand bit 2.
- A4  input  1  operand bit 3.
- A5  input  1  operand bit 4.
- A6  input  1  operand bit 5.
- A7  input  1  operand bit 6.
- A8  input  1  operand bit 7 (MSB).
- S1..S8  output  1 each  combinational NOT of A1..A8 respectively (S1 = ~A1 ... S8 = ~A8).
- en  input  1  load enable for the registered copy.
- s_q  output  8  registered inverted byte; s_q[i] holds the value of S(i+1).

Behaviour:
- Combinational path:
  - S(i) = ~A(i) for i = 1..8, bit-independent, zero cycles of latency.
  - Must settle within the same delta/time step as the input change; a bench sampling 1 time unit after driving A sees the final value.
  - Each bit is implemented as its own primitive NOT instance; there is no cross-bit logic.
  - X or Z on A(i) produces X on S(i); other bits are unaffected.
  - The combinational path is unaffected by rst and en. S follows A even while rst=1.
- Registered path:
  - While rst=1: s_q = 8'h00, asynchronously.
  - On the rising edge of clk with rst=0 and en=1: s_q <= {S8,S7,S6,S5,S4,S3,S2,S1}, giving one cycle of latency relative to A.
  - With en=0: s_q holds its value.
  - Reset asserted mid-operation clears s_q immediately, regardless of clk.
  - On rst deassertion, the first load occurs at the next rising clk edge with en=1.
- No handshake, no state machine, no arithmetic. Widths match exactly, with no extension or truncation.

Decomposition:
- Shared package: constant NOT_WIDTH = 8 and the reset value NOT_RST_VAL = 8'h00.
- Sub-module not_1_bit (in, out): a single NOT gate, instantiated 8 times.
- The register is written inline in not_8_bits.

Test Plan:
- A = 1111_1111, wait 1 time unit -> S8..S1 = 0000_0000 (no clock edge required).
- A = 0000_0000 -> S8..S1 = 1111_1111.
- A = 1001_1001 -> S8..S1 = 0110_0110.
- A = 1111_0000 -> S8..S1 = 0000_1111; then en=1, one clk edge -> s_q = 8'h0F.
- rst=1 with A = 0000_0000 -> s_q = 8'h00 immediately while S = 1111_1111. Release rst, en=0, clk edge -> s_q stays 8'h00. Set en=1, clk edge -> s_q = 8'hFF.
- Walking-one on A1..A8 -> exactly one S bit low at the matching position each step; assert rst mid-sequence -> s_q = 8'h00 asynchronously and S is unaffected.
